// File: rtl/fsqrt_arb_pkg.sv
// Shared types and constants for the fsqrt arbiter and its result FIFOs.
package fsqrt_arb_pkg;

  localparam int FP_W     = 32;
  localparam int NREQ_DEF = 2;
  localparam int TAG_W    = $clog2(NREQ_DEF);

  typedef logic [FP_W-1:0] float32_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } sqrt_tag_t;

  localparam float32_t FP_ZERO = 32'h0;

endpackage

// File: rtl/fsqrt_res_fifo.sv
// Synchronous single-clock result FIFO; head reads 0 while empty.
module fsqrt_res_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fsqrt_arbiter.sv
// Round-robin, credit-based sharing of one fixed-latency fsqrt unit among NREQ requesters.
// Optional FSQRT_ARB_BYPASS_EN: results landing on an empty FIFO are offered the same cycle.
module fsqrt_arbiter
  import fsqrt_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int LATENCY   = 2,
  parameter int RES_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic     [NREQ-1:0]  req_valid,
  input  float32_t [NREQ-1:0]  req_x,
  output logic     [NREQ-1:0]  req_ready,
  output logic     [NREQ-1:0]  res_valid,
  output float32_t [NREQ-1:0]  res_y,
  input  logic     [NREQ-1:0]  res_ready,
  output float32_t             sqrt_x,
  input  float32_t             sqrt_y,
  output logic                 busy
);
  localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(RES_DEPTH + 1);

  logic [TW-1:0]  prio, gnt_idx, scan;
  logic           gnt_any;
  logic [NREQ-1:0] elig, grant, land, push, pop, take, empty, full;
  float32_t [NREQ-1:0] head;
  logic [CW-1:0]  credit [NREQ];
  logic [LATENCY-1:0] vld_p;
  logic [TW-1:0]  tag_p [LATENCY];

  // Arbitration: first eligible requester scanning upward from prio.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    scan    = prio;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_any && elig[scan]) begin
        gnt_any = 1'b1;
        gnt_idx = scan;
      end
      scan = (scan == TW'(NREQ - 1)) ? '0 : scan + 1'b1;
    end
  end

  assign req_ready = grant;
  assign sqrt_x    = gnt_any ? req_x[gnt_idx] : FP_ZERO;
  assign busy      = (|vld_p) || !(&empty);

  always_ff @(posedge clk) begin
    if (rst)          prio <= '0;
    else if (gnt_any) prio <= (gnt_idx == TW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Tag pipeline stages p0..p(LATENCY-1), aligned with the fsqrt pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= gnt_any;
      for (int s = 1; s < LATENCY; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_p[0] <= gnt_idx;
    for (int s = 1; s < LATENCY; s++) tag_p[s] <= tag_p[s-1];
  end

  // Result steering, per-requester FIFOs and pop handshake.
  for (genvar i = 0; i < NREQ; i++) begin : g_req
    assign elig[i]  = req_valid[i] && (credit[i] != '0) && !rst;
    assign grant[i] = gnt_any && (gnt_idx == TW'(i));
    assign land[i]  = vld_p[LATENCY-1] && (tag_p[LATENCY-1] == TW'(i));
`ifdef FSQRT_ARB_BYPASS_EN
    logic byp;
    assign byp          = land[i] && empty[i];
    assign res_valid[i] = !rst && (!empty[i] || byp);
    assign res_y[i]     = rst       ? FP_ZERO :
                          !empty[i] ? head[i] :
                          byp       ? sqrt_y  : FP_ZERO;
    assign push[i]      = land[i] && !(byp && res_ready[i]);
`else
    assign res_valid[i] = !rst && !empty[i];
    assign res_y[i]     = rst ? FP_ZERO : head[i];
    assign push[i]      = land[i];
`endif
    assign take[i] = res_valid[i] && res_ready[i];
    assign pop[i]  = take[i] && !empty[i];

    fsqrt_res_fifo #(
      .DEPTH (RES_DEPTH),
      .W     (FP_W)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .din   (sqrt_y),
      .pop   (pop[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .head  (head[i])
    );
  end

  // A credit reserves a FIFO slot from issue until the result is consumed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (rst)                        credit[i] <= CW'(RES_DEPTH);
      else if (grant[i] && !take[i])  credit[i] <= credit[i] - 1'b1;
      else if (!grant[i] && take[i])  credit[i] <= credit[i] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert ((push & full & ~pop) == '0);
  end

endmodule

// File: tb/tb_fsqrt_arbiter.sv
// Directed bench for fsqrt_arbiter with a 2-stage fsqrt stand-in driven by a lookup table.
module tb_fsqrt_arbiter;
  import fsqrt_arb_pkg::*;

  localparam int NREQ      = 2;
  localparam int LATENCY   = 2;
  localparam int RES_DEPTH = 4;
`ifdef FSQRT_ARB_BYPASS_EN
  localparam int RL = LATENCY;
`else
  localparam int RL = LATENCY + 1;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic     [NREQ-1:0] req_valid, req_ready, res_valid, res_ready;
  float32_t [NREQ-1:0] req_x, res_y;
  float32_t            sqrt_x, sqrt_y;
  logic                busy;
  float32_t            sq_p0, sq_p1;
  int                  n_chk = 0;
  int                  n_err = 0;

  float32_t x1tab [5] = '{32'h40800000, 32'h41100000, 32'h40000000, 32'h00000000, 32'h40800000};
  float32_t y1tab [4] = '{32'h40000000, 32'h40400000, 32'h3FB504F3, 32'h00000000};

  always #5 clk = ~clk;

  fsqrt_arbiter #(
    .NREQ      (NREQ),
    .LATENCY   (LATENCY),
    .RES_DEPTH (RES_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_y     (res_y),
    .res_ready (res_ready),
    .sqrt_x    (sqrt_x),
    .sqrt_y    (sqrt_y),
    .busy      (busy)
  );

  function automatic float32_t ref_sqrt(input float32_t x);
    case (x)
      32'h40800000: return 32'h40000000;
      32'h41100000: return 32'h40400000;
      32'h40000000: return 32'h3FB504F3;
      32'h00000000: return 32'h00000000;
      default:      return x ^ 32'hA5A5A5A5;
    endcase
  endfunction

  always @(posedge clk) begin
    sq_p0 <= ref_sqrt(sqrt_x);
    sq_p1 <= sq_p0;
  end
  assign sqrt_y = sq_p1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    res_ready = '0;
    req_x     = '0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    smp();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_y0", res_y[0], 0);
    chk("rst_res_y1", res_y[1], 0);
    chk("rst_sqrt_x", sqrt_x, 0);
    chk("rst_busy", busy, 0);
    cyc();

    // single op on requester 0
    req_valid = 2'b01;
    req_x[0]  = 32'h40800000;
    res_ready = 2'b11;
    smp();
    chk("t1_ready", req_ready, 2'b01);
    chk("t1_sqrt_x", sqrt_x, 32'h40800000);
    cyc();
    req_valid = 2'b00;
    for (int k = 1; k <= RL + 1; k++) begin
      smp();
      chk("t1_res_valid", res_valid, (k == RL) ? 2'b01 : 2'b00);
      if (k == RL) chk("t1_res_y", res_y[0], 32'h40000000);
      chk("t1_busy", busy, (k <= RL) ? 1 : 0);
      cyc();
    end

    // both requesters streaming: strict alternation from 0
    do_reset();
    req_x[0]  = 32'h41100000;
    req_x[1]  = 32'h40000000;
    res_ready = 2'b11;
    for (int c = 0; c < 12; c++) begin
      logic e0, e1;
      req_valid = (c < 8) ? 2'b11 : 2'b00;
      e0 = (c >= RL) && (c <= RL + 6) && ((c - RL) % 2 == 0);
      e1 = (c >= RL + 1) && (c <= RL + 7) && ((c - RL - 1) % 2 == 0);
      smp();
      if (c < 8) chk("t2_grant", req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
      chk("t2_res_valid", res_valid, {e1, e0});
      if (e0) chk("t2_res_y0", res_y[0], 32'h40400000);
      if (e1) chk("t2_res_y1", res_y[1], 32'h3FB504F3);
      cyc();
    end

    // backpressure on requester 1 until its credits run out
    do_reset();
    res_ready = 2'b01;
    for (int c = 0; c < 18; c++) begin
      req_valid = (c < 12) ? 2'b11 : ((c < 14) ? 2'b10 : 2'b00);
      if (c >= 12) res_ready = 2'b11;
      req_x[0] = 32'h41100000;
      req_x[1] = x1tab[(c < 8) ? c / 2 : ((c < 12) ? 3 : 4)];
      smp();
      if (c < 8)        chk("t3_grant_alt", req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
      else if (c < 12)  chk("t3_grant_r0", req_ready, 2'b01);
      else if (c == 12) chk("t3_no_credit", req_ready, 2'b00);
      else if (c == 13) chk("t3_regrant", req_ready, 2'b10);
      if (c >= 12 && c <= 15) begin
        chk("t3_res_valid1", res_valid[1], 1);
        chk("t3_res_y1", res_y[1], y1tab[c - 12]);
      end
      if (c == 16) begin
        chk("t3_new_valid1", res_valid[1], 1);
        chk("t3_new_y1", res_y[1], 32'h40000000);
      end
      if (c == 17) begin
        chk("t3_drained", res_valid, 2'b00);
        chk("t3_busy", busy, 0);
      end
      cyc();
    end

    // reset while two ops are in flight
    do_reset();
    for (int c = 0; c < 11; c++) begin
      rst       = (c == 2);
      req_valid = (c < 2) ? 2'b11 : ((c >= 6) ? 2'b01 : 2'b00);
      req_x[0]  = 32'h40800000;
      req_x[1]  = 32'h41100000;
      smp();
      if (c == 0) chk("t4_grant0", req_ready, 2'b01);
      if (c == 1) chk("t4_grant1", req_ready, 2'b10);
      if (c >= 3 && c <= 5) begin
        chk("t4_no_result", res_valid, 2'b00);
        chk("t4_busy", busy, 0);
      end
      if (c >= 6) chk("t4_burst", req_ready, (c < 10) ? 2'b01 : 2'b00);
      if (c >= 3) chk("t4_res_valid1", res_valid[1], 0);
      if (c == 10) chk("t4_res_valid0", res_valid[0], 1);
      cyc();
    end

`ifdef FSQRT_ARB_BYPASS_EN
    // bypass result held in the FIFO when not consumed
    do_reset();
    req_valid = 2'b01;
    req_x[0]  = 32'h40800000;
    smp();
    chk("t5_ready", req_ready, 2'b01);
    cyc();
    req_valid = 2'b00;
    for (int k = 1; k <= 5; k++) begin
      if (k == 4) res_ready = 2'b01;
      smp();
      chk("t5_res_valid", res_valid, (k >= 2 && k <= 4) ? 2'b01 : 2'b00);
      if (k >= 2 && k <= 4) chk("t5_res_y", res_y[0], 32'h40000000);
      cyc();
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
